controle_rodada_metronomo: RTL and testbench
============================================

# controle_rodada_metronomo

Round sequencer for the metronome datapath. It starts, pauses, resumes and aborts a round of N beats by driving the metronome's zero/count/tempo-select inputs, and consumes the metronome's `metro`/`meio_metro` pulses. It emits one-cycle beat and half-beat events, a beat index and an end-of-round pulse, so the game FSM never touches the metronome counters directly.

## Interface
- `MAX_BATIDAS`, default 16: maximum beats per round.
- `W`, default `$clog2(MAX_BATIDAS+1)`: width of beat count and index.

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces OCIOSO and all outputs to reset values.
- `iniciar` in 1: start request, sampled only in OCIOSO.
- `pausar` in 1: level; hold round while high.
- `abortar` in 1: synchronous abort, highest priority after reset.
- `tempo_120` in 1: tempo select, 1 = 120 BPM, latched at start.
- `num_batidas` in W: beats in round, latched at start; valid 1..MAX_BATIDAS.
- `metro` in 1: beat pulse from metronome.
- `meio_metro` in 1: half-beat pulse from metronome.
- `zeraMetro` out 1: synchronous clear to metronome.
- `contaMetro` out 1: count enable to metronome.
- `metro_120BPM` out 1: latched tempo select.
- `batida` out 1: one-cycle pulse per counted beat.
- `meia_batida` out 1: one-cycle pulse per counted half-beat.
- `indice_batida` out W: beats completed in current round.
- `ocupado` out 1: high in every state except OCIOSO.
- `fim_rodada` out 1: one-cycle pulse on normal completion.
- `db_estado` out 3: state encoding, debug.

## Operation
- States: OCIOSO, PREPARA, CONTANDO, PAUSADO, FIM. Moore outputs are decoded from the registered state.
- OCIOSO: `zeraMetro`=1, `contaMetro`=0.
  - `iniciar` with `num_batidas` in 1..MAX: latch `num_batidas` and `tempo_120`, clear the index, go to PREPARA.
  - `iniciar` with `num_batidas`=0 or >MAX: ignored; stay in OCIOSO.
- PREPARA: `zeraMetro`=1, `contaMetro`=0 for exactly one cycle, then go to CONTANDO.
- CONTANDO: `contaMetro`=1, `zeraMetro`=0.
  - A counted `metro` increments `indice_batida` and pulses `batida`.
  - If the incremented index equals the latched N, go to FIM.
  - Otherwise, if `pausar`=1, go to PAUSADO.
- PAUSADO: `contaMetro`=0, `zeraMetro`=0, so the metronome holds its count. Go to CONTANDO when `pausar`=0.
- FIM: `fim_rodada`=1 and `zeraMetro`=1 for one cycle, then go to OCIOSO. `indice_batida` keeps N until the next start.
- `abortar` in PREPARA, CONTANDO or PAUSADO: go to OCIOSO next cycle. No `fim_rodada`; the index is held.
- Priority in the same cycle: `reset` > `abortar` > `metro` (beat counted) > `pausar`. A beat coincident with `pausar` is counted, then the block enters PAUSADO. A final beat coincident with `pausar` goes to FIM.
- Pulse consumption: `metro` and `meio_metro` are each counted at most once per contiguous high interval, and only while in CONTANDO. This covers the metronome end flag staying high through a pause and into resume. A consumed flag is set on count and cleared when the input is low.
- `meia_batida` follows the same rules but never changes the index or state.
- `iniciar`, `tempo_120` and `num_batidas` changes while `ocupado` are ignored.

## Timing
- Reset values:
  - state OCIOSO;
  - `zeraMetro`=1, `contaMetro`=0, `metro_120BPM`=0;
  - `batida`=0, `meia_batida`=0, `fim_rodada`=0;
  - `indice_batida`=0, `ocupado`=0, `db_estado`=0.
- `iniciar` sampled at edge k: PREPARA from k+1, CONTANDO from k+2.
- `batida`, `meia_batida` and the index update are registered: they appear one cycle after the qualifying `metro` sample.
- Last beat sampled at edge k: `batida` and the index equal to N at k+1, FIM (`fim_rodada`) at k+1, OCIOSO at k+2.
- The first beat arrives one full metronome period after PREPARA, since the metronome starts from zero.
- A pause of any length adds exactly its duration to the round. No beat is lost or duplicated.

## Structure
- Shared package `metronomo_pkg`:
  - state enum/encoding: OCIOSO=0, PREPARA=1, CONTANDO=2, PAUSADO=3, FIM=4;
  - tempo-select constants.
- One sub-module, `consome_pulso`, instantiated twice (`metro`, `meio_metro`):
  - inputs: `clock`, `reset`, `en`, `pulso`;
  - output: registered single-cycle `evento`.
- The FSM and index counter live in the top module.

## Test plan
- Reset mid-round, then `iniciar` with N=3, `tempo_120`=0, `metro` every 10 cycles:
  - exactly 3 `batida` pulses, index steps 1,2,3;
  - `fim_rodada` in the same cycle as the third beat, then OCIOSO;
  - `metro_120BPM`=0 throughout.
- Pause crossing a beat: `pausar` held 25 cycles while `metro` stays high throughout (stuck end flag), then released:
  - exactly one `batida` for that beat;
  - `contaMetro`=0 while paused;
  - no duplicate on resume.
- `metro` and `pausar` in the same cycle, with N=2 and this the second beat:
  - beat counted, index=2;
  - FIM reached, not PAUSADO.
- `abortar` after 1 of 4 beats:
  - OCIOSO next cycle, no `fim_rodada`, index holds 1;
  - `zeraMetro`=1 afterwards.
- `iniciar` with `num_batidas`=0, then with 17 (MAX=16):
  - stays in OCIOSO, `ocupado`=0.
  - `iniciar` during CONTANDO with new N and tempo: ignored; the round ends at the original N.
- Async reset asserted between clock edges during CONTANDO:
  - all outputs take reset values immediately;
  - next `iniciar` behaves as from power-up.

Source files
------------

// File: rtl/metronomo_pkg.sv
// Shared definitions for the metronome round sequencer: state encoding and
// tempo-select values.
package metronomo_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        PREPARA  = 3'd1,
        CONTANDO = 3'd2,
        PAUSADO  = 3'd3,
        FIM      = 3'd4
    } estado_t;

    localparam logic TEMPO_120BPM = 1'b1;
    localparam logic TEMPO_PADRAO = 1'b0;

endpackage

// File: rtl/consome_pulso.sv
// Counts a level pulse at most once per contiguous high interval, only while
// enabled; emits a registered one-cycle event one cycle after the count.
module consome_pulso (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic pulso,
    output logic conta,
    output logic evento
);

    logic consumido_q, consumido_d;
    logic evento_q;

    // conta is the same-cycle qualification, needed by the FSM to decide its
    // next state on the very edge that samples the pulse.
    assign conta = en & pulso & ~consumido_q;

    always_comb begin
        consumido_d = consumido_q;
        if (!pulso)
            consumido_d = 1'b0;
        else if (conta)
            consumido_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            consumido_q <= 1'b0;
            evento_q    <= 1'b0;
        end else begin
            consumido_q <= consumido_d;
            evento_q    <= conta;
        end
    end

    assign evento = evento_q;

endmodule

// File: rtl/controle_rodada_metronomo.sv
// Round sequencer: starts, pauses, resumes and aborts a round of N beats,
// driving the metronome controls and turning its pulses into beat events.
module controle_rodada_metronomo
    import metronomo_pkg::*;
#(
    parameter int MAX_BATIDAS = 16,
    parameter int W           = $clog2(MAX_BATIDAS + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         pausar,
    input  logic         abortar,
    input  logic         tempo_120,
    input  logic [W-1:0] num_batidas,
    input  logic         metro,
    input  logic         meio_metro,
    output logic         zeraMetro,
    output logic         contaMetro,
    output logic         metro_120BPM,
    output logic         batida,
    output logic         meia_batida,
    output logic [W-1:0] indice_batida,
    output logic         ocupado,
    output logic         fim_rodada,
    output logic [2:0]   db_estado
);

    estado_t        estado_q, estado_d;
    logic [W-1:0]   num_q, num_d;
    logic [W-1:0]   idx_q, idx_d;
    logic           tempo_q, tempo_d;

    logic           en_conta;
    logic           conta_metro;
    logic           meia_conta_unused;
    logic           inicio_ok;
    logic [W-1:0]   idx_inc;

    // abortar outranks a coincident beat, so counting is gated by it too.
    assign en_conta  = (estado_q == CONTANDO) && !abortar;
    assign inicio_ok = iniciar && (num_batidas != '0) &&
                       (num_batidas <= W'(MAX_BATIDAS));
    assign idx_inc   = idx_q + W'(1);

    consome_pulso u_metro (
        .clock  (clock),
        .reset  (reset),
        .en     (en_conta),
        .pulso  (metro),
        .conta  (conta_metro),
        .evento (batida)
    );

    consome_pulso u_meio (
        .clock  (clock),
        .reset  (reset),
        .en     (en_conta),
        .pulso  (meio_metro),
        .conta  (meia_conta_unused),
        .evento (meia_batida)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:   if (inicio_ok) estado_d = PREPARA;
            PREPARA:  estado_d = abortar ? OCIOSO : CONTANDO;
            CONTANDO: begin
                if (abortar)
                    estado_d = OCIOSO;
                else if (conta_metro && (idx_inc == num_q))
                    estado_d = FIM;
                else if (pausar)
                    estado_d = PAUSADO;
            end
            PAUSADO: begin
                if (abortar)
                    estado_d = OCIOSO;
                else if (!pausar)
                    estado_d = CONTANDO;
            end
            FIM:      estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        num_d   = num_q;
        idx_d   = idx_q;
        tempo_d = tempo_q;
        if ((estado_q == OCIOSO) && inicio_ok) begin
            num_d   = num_batidas;
            tempo_d = tempo_120;
            idx_d   = '0;
        end
        if (conta_metro)
            idx_d = idx_inc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            num_q    <= '0;
            idx_q    <= '0;
            tempo_q  <= TEMPO_PADRAO;
        end else begin
            estado_q <= estado_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            tempo_q  <= tempo_d;
        end
    end

    // Moore outputs; PAUSADO drops both controls so the metronome holds.
    always_comb begin
        zeraMetro  = 1'b0;
        contaMetro = 1'b0;
        fim_rodada = 1'b0;
        case (estado_q)
            OCIOSO, PREPARA: zeraMetro = 1'b1;
            CONTANDO:        contaMetro = 1'b1;
            PAUSADO:         ;
            FIM: begin
                zeraMetro  = 1'b1;
                fim_rodada = 1'b1;
            end
            default:         zeraMetro = 1'b1;
        endcase
    end

    assign ocupado       = (estado_q != OCIOSO);
    assign db_estado     = estado_q;
    assign indice_batida = idx_q;
    assign metro_120BPM  = tempo_q;

endmodule

// File: tb/tb_controle_rodada_metronomo.sv
// Scoreboard bench: a behavioural round model queues expected beat/half-beat/
// end events; a negedge monitor pops them as the DUT presents its pulses.
module tb_controle_rodada_metronomo;
    import metronomo_pkg::*;

    localparam int MAXB = 16;
    localparam int W    = $clog2(MAXB + 1);

    logic         clock = 1'b0;
    logic         reset, iniciar, pausar, abortar, tempo_120, metro, meio_metro;
    logic [W-1:0] num_batidas;
    logic         zeraMetro, contaMetro, metro_120BPM, batida, meia_batida;
    logic [W-1:0] indice_batida;
    logic         ocupado, fim_rodada;
    logic [2:0]   db_estado;

    always #5 clock = ~clock;

    controle_rodada_metronomo #(.MAX_BATIDAS(MAXB), .W(W)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
        .abortar(abortar), .tempo_120(tempo_120), .num_batidas(num_batidas),
        .metro(metro), .meio_metro(meio_metro), .zeraMetro(zeraMetro),
        .contaMetro(contaMetro), .metro_120BPM(metro_120BPM), .batida(batida),
        .meia_batida(meia_batida), .indice_batida(indice_batida),
        .ocupado(ocupado), .fim_rodada(fim_rodada), .db_estado(db_estado)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic falha(input string nm, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE = 0, M_PREP = 1, M_RUN = 2, M_PAUSE = 3, M_END = 4} mph_t;
    typedef struct {int fim; int idx; int cyc;} ev_t;

    ev_t  q_ev[$];
    int   q_half[$];
    mph_t m_ph = M_IDLE;
    int   m_n = 0, m_idx = 0, m_tempo = 0;
    bit   m_mdone = 0, m_hdone = 0;
    int   cyc = 0;
    int   fim_cnt = 0, bat_cnt = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ph = M_IDLE; m_idx = 0; m_tempo = 0; m_n = 0;
            m_mdone = 0; m_hdone = 0;
            q_ev.delete(); q_half.delete();
        end else begin
            cyc++;
            case (m_ph)
                M_IDLE: if (iniciar && num_batidas >= 1 && num_batidas <= MAXB) begin
                    m_n = int'(num_batidas); m_tempo = int'(tempo_120); m_idx = 0; m_ph = M_PREP;
                end
                M_PREP: m_ph = abortar ? M_IDLE : M_RUN;
                M_RUN: if (abortar) m_ph = M_IDLE;
                else begin
                    if (metro && !m_mdone) begin
                        m_mdone = 1; m_idx++;
                        q_ev.push_back('{0, m_idx, cyc});
                        if (m_idx == m_n) begin
                            q_ev.push_back('{1, m_idx, cyc});
                            m_ph = M_END;
                        end
                    end
                    if (meio_metro && !m_hdone) begin
                        m_hdone = 1;
                        q_half.push_back(cyc);
                    end
                    if (m_ph == M_RUN && pausar) m_ph = M_PAUSE;
                end
                M_PAUSE: if (abortar) m_ph = M_IDLE; else if (!pausar) m_ph = M_RUN;
                M_END: m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
            if (!metro) m_mdone = 0;
            if (!meio_metro) m_hdone = 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        ev_t e;
        if (!reset) begin
            chk("zeraMetro", zeraMetro, int'(m_ph == M_IDLE || m_ph == M_PREP || m_ph == M_END));
            chk("contaMetro", contaMetro, int'(m_ph == M_RUN));
            chk("ocupado", ocupado, int'(m_ph != M_IDLE));
            chk("db_estado", db_estado, int'(m_ph));
            chk("metro_120BPM", metro_120BPM, m_tempo);
            chk("indice_batida", indice_batida, m_idx);
            if (batida) begin
                if (q_ev.size() == 0 || q_ev[0].fim != 0)
                    falha("batida_inesperada", int'(indice_batida), -1);
                else begin
                    e = q_ev.pop_front();
                    chk("batida_ciclo", cyc, e.cyc);
                    chk("batida_indice", indice_batida, e.idx);
                    bat_cnt++;
                end
            end
            if (fim_rodada) begin
                if (q_ev.size() == 0 || q_ev[0].fim != 1)
                    falha("fim_inesperado", int'(indice_batida), -1);
                else begin
                    e = q_ev.pop_front();
                    chk("fim_ciclo", cyc, e.cyc);
                    chk("fim_indice", indice_batida, e.idx);
                    fim_cnt++;
                end
            end
            if (meia_batida) begin
                if (q_half.size() == 0)
                    falha("meia_inesperada", cyc, -1);
                else
                    chk("meia_ciclo", cyc, q_half.pop_front());
            end
            while (q_ev.size() > 0 && q_ev[0].cyc <= cyc) begin
                e = q_ev.pop_front();
                falha(e.fim ? "fim_perdido" : "batida_perdida", 0, e.idx);
            end
            while (q_half.size() > 0 && q_half[0] <= cyc)
                falha("meia_perdida", 0, q_half.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input int n, input bit t);
        iniciar = 1'b1; num_batidas = W'(n); tempo_120 = t;
        tick();
        iniciar = 1'b0;
    endtask

    initial begin
        int b0, f0;
        reset = 1'b1; iniciar = 0; pausar = 0; abortar = 0; tempo_120 = 0;
        metro = 0; meio_metro = 0; num_batidas = '0;
        ticks(2);
        chk("rst_zera", zeraMetro, 1);
        chk("rst_conta", contaMetro, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_batida", batida, 0);
        chk("rst_fim", fim_rodada, 0);
        reset = 1'b0;
        tick();

        // round interrupted by an asynchronous reset between edges
        start(4, 1'b1);
        ticks(3);
        metro = 1; tick(); metro = 0;
        ticks(2);
        chk("pre_rst_indice", indice_batida, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_zera", zeraMetro, 1);
        chk("arst_conta", contaMetro, 0);
        chk("arst_tempo", metro_120BPM, 0);
        chk("arst_indice", indice_batida, 0);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_estado", db_estado, 0);
        tick(); reset = 1'b0; tick();

        // N=3, 60-ish tempo, metro every 10 cycles
        b0 = bat_cnt; f0 = fim_cnt;
        start(3, 1'b0);
        for (int i = 0; i < 45; i++) begin
            metro = (i % 10 == 9);
            tick();
        end
        metro = 0; ticks(3);
        chk("A_batidas", bat_cnt - b0, 3);
        chk("A_fins", fim_cnt - f0, 1);
        chk("A_indice", indice_batida, 3);
        chk("A_ocupado", ocupado, 0);

        // pause crossing a beat with metro stuck high
        b0 = bat_cnt; f0 = fim_cnt;
        start(3, 1'b0);
        ticks(4);
        metro = 1; pausar = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 12) chk("B_conta_pausa", contaMetro, 0);
        end
        pausar = 0; ticks(3);
        metro = 0; tick();
        chk("B_uma_batida", bat_cnt - b0, 1);
        for (int i = 0; i < 25; i++) begin
            metro = (i % 10 == 5);
            tick();
        end
        metro = 0; ticks(2);
        chk("B_batidas", bat_cnt - b0, 3);
        chk("B_fins", fim_cnt - f0, 1);

        // final beat coincident with pausar
        start(2, 1'b1);
        ticks(3);
        metro = 1; tick(); metro = 0;
        ticks(4);
        metro = 1; pausar = 1; tick(); metro = 0; pausar = 0;
        chk("C_estado_fim", db_estado, 4);
        chk("C_indice", indice_batida, 2);
        chk("C_fim", fim_rodada, 1);
        tick();
        chk("C_ocioso", db_estado, 0);

        // abort after one beat of four
        f0 = fim_cnt;
        start(4, 1'b0);
        ticks(3);
        metro = 1; tick(); metro = 0;
        ticks(3);
        abortar = 1; tick(); abortar = 0;
        chk("D_estado", db_estado, 0);
        chk("D_indice", indice_batida, 1);
        chk("D_zera", zeraMetro, 1);
        ticks(3);
        chk("D_sem_fim", fim_cnt - f0, 0);

        // invalid N, then start requests ignored while busy
        start(0, 1'b1); tick();
        chk("E_n0", ocupado, 0);
        start(17, 1'b1); tick();
        chk("E_n17", ocupado, 0);
        b0 = bat_cnt; f0 = fim_cnt;
        start(2, 1'b1);
        ticks(3);
        iniciar = 1; num_batidas = W'(5); tempo_120 = 0; tick(); iniciar = 0;
        for (int i = 0; i < 20; i++) begin
            metro = (i % 8 == 3);
            tick();
        end
        metro = 0; ticks(2);
        chk("E_batidas", bat_cnt - b0, 2);
        chk("E_fins", fim_cnt - f0, 1);
        chk("E_tempo", metro_120BPM, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) metro = ~metro;
            if ($urandom_range(0, 2) == 0) meio_metro = ~meio_metro;
            if ($urandom_range(0, 9) == 0) pausar = ~pausar;
            abortar     = ($urandom_range(0, 60) == 0);
            iniciar     = ($urandom_range(0, 5) == 0);
            num_batidas = W'($urandom_range(0, 20));
            tempo_120   = 1'($urandom_range(0, 1));
            tick();
        end
        iniciar = 0; pausar = 0; metro = 0; meio_metro = 0;
        abortar = 1; tick(); abortar = 0;
        ticks(3);
        chk("filas_vazias", q_ev.size() + q_half.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
